// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      StReq  = 2'd0,
      StDrop = 2'd1,
      StFull = 2'd2
   } fetch_state_e;

   localparam logic [31:0] ResetPcDefault = 32'h0000_0000;
   localparam logic [31:0] Nop            = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam fetch_entry_t EmptyEntry = '{pc4: 32'h0000_0000, instr: Nop};

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between fetch unit (master) and memory (slave).
interface fetch_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buf2.sv
// Two-entry in-order instruction buffer; head entry is held in registers and cleared when empty.
module fetch_buf2
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         empty_o,
   output logic         head_valid_o,
   output fetch_entry_t head_o
);

   // valid_q[0] marks the head, valid_q[1] the tail; tail valid implies head valid.
   logic [1:0]   valid_q, valid_d;
   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic         pop_ok;

   assign pop_ok = pop_i && valid_q[0];

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush_i) begin
         valid_d = 2'b00;
         head_d  = EmptyEntry;
         tail_d  = EmptyEntry;
      end else begin
         case ({push_i, pop_ok})
            2'b10: begin
               if (!valid_q[0]) begin
                  head_d     = push_data_i;
                  valid_d[0] = 1'b1;
               end else begin
                  tail_d     = push_data_i;
                  valid_d[1] = 1'b1;
               end
            end
            2'b01: begin
               if (valid_q[1]) begin
                  head_d  = tail_q;
                  tail_d  = EmptyEntry;
                  valid_d = 2'b01;
               end else begin
                  head_d  = EmptyEntry;
                  valid_d = 2'b00;
               end
            end
            2'b11: begin
               if (valid_q[1]) begin
                  head_d = tail_q;
                  tail_d = push_data_i;
               end else begin
                  head_d  = push_data_i;
                  valid_d = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 2'b00;
         head_q  <= EmptyEntry;
         tail_q  <= EmptyEntry;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign full_o       = valid_q[1];
   assign empty_o      = !valid_q[0];
   assign head_valid_o = valid_q[0];
   assign head_o       = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch, redirect/drop handling, 2-entry decode buffer.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = ResetPcDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic        redirect_in,
   input  logic [31:0] redirect_pc_in,
   fetch_if.master     imem,
   output logic        instr_valid_out,
   output logic [31:0] PC_4_out,
   output logic [31:0] instr_out
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  drop_addr_q, drop_addr_d;

   logic         complete;
   logic         consume;
   logic         buf_push;
   logic         buf_flush;
   logic         buf_full;
   logic         buf_empty;
   logic         head_valid;
   fetch_entry_t head;
   fetch_entry_t push_entry;
   logic [1:0]   occ;
   logic [1:0]   occ_next;

   // In StDrop the bus keeps the abandoned address while pc_q already holds the new target.
   assign imem.imem_req  = !rst && (state_q != StFull);
   assign imem.imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

   assign complete   = imem.imem_req && imem.imem_ack;
   assign consume    = head_valid && !stall_in && !redirect_in;
   assign push_entry = '{pc4: pc_q + 32'd4, instr: imem.imem_rdata};

   assign occ      = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
   assign occ_next = occ + 2'd1 - {1'b0, consume};

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      buf_push    = 1'b0;
      buf_flush   = 1'b0;
      if (redirect_in) begin
         pc_d      = word_align(redirect_pc_in);
         buf_flush = 1'b1;
         unique case (state_q)
            StReq: begin
               if (!complete) begin
                  state_d     = StDrop;
                  drop_addr_d = pc_q;
               end
            end
            // A drop completing together with a new redirect has nothing left to discard.
            StDrop:  if (complete) state_d = StReq;
            StFull:  state_d = StReq;
            default: state_d = StReq;
         endcase
      end else begin
         unique case (state_q)
            StReq: begin
               if (complete) begin
                  buf_push = 1'b1;
                  pc_d     = pc_q + 32'd4;
                  if (occ_next >= 2'd2) state_d = StFull;
               end
            end
            StDrop:  if (complete) state_d = StReq;
            StFull:  if (consume) state_d = StReq;
            default: state_d = StReq;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StReq;
         pc_q        <= word_align(RESET_PC);
         drop_addr_q <= word_align(RESET_PC);
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   fetch_buf2 u_buf (
      .clk          (clk),
      .rst          (rst),
      .push_i       (buf_push),
      .push_data_i  (push_entry),
      .pop_i        (consume),
      .flush_i      (buf_flush),
      .full_o       (buf_full),
      .empty_o      (buf_empty),
      .head_valid_o (head_valid),
      .head_o       (head)
   );

   assign instr_valid_out = head_valid;
   assign PC_4_out        = head.pc4;
   assign instr_out       = head.instr;

   a_push_room: assert property (@(posedge clk) disable iff (rst)
      buf_push |-> (!buf_full || consume));

   a_addr_align: assert property (@(posedge clk) disable iff (rst)
      imem.imem_req |-> (imem.imem_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random memory latency, stalls, redirects and resets.
module tb_fetch_unit;

   localparam logic [31:0] TbResetPc = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;
   logic        instr_valid_out;
   logic [31:0] PC_4_out;
   logic [31:0] instr_out;

   fetch_if bus ();

   fetch_unit #(
      .RESET_PC (TbResetPc)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_in        (stall_in),
      .redirect_in     (redirect_in),
      .redirect_pc_in  (redirect_pc_in),
      .imem            (bus),
      .instr_valid_out (instr_valid_out),
      .PC_4_out        (PC_4_out),
      .instr_out       (instr_out)
   );

   int          n_tests;
   int          n_fail;
   int          n_deliv;
   int          ack_mode;  // 0 never ack, 1 always ack, 2 random ack
   logic [31:0] seed;
   exp_t        sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected delivery stream after a redirect/reset to t: consecutive words from t onwards.
   task automatic restart_stream(input logic [31:0] t);
      logic [31:0] a;
      sb.delete();
      a = {t[31:2], 2'b00};
      for (int j = 0; j < 256; j++) begin
         sb.push_back('{pc4: a + 32'd4, instr: mem_word(a)});
         a = a + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers on the bus shortly after each rising edge.
   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.imem_req && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 2) != 0))) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
         end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hDEAD_BEEF;
         end
      end
   end

   // Monitor: pops the scoreboard on every handoff and checks bus rules.
   initial begin
      logic        pend;
      logic [31:0] pend_addr;
      exp_t        e;
      pend      = 1'b0;
      pend_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
            pend = 1'b0;
         end else begin
            if (bus.imem_req) check("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
            if (pend && bus.imem_req) check("addr_stable", bus.imem_addr, pend_addr);
            if (instr_valid_out && !stall_in && !redirect_in) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_handoff: got pc4 %h expected none", PC_4_out);
               end else begin
                  e = sb.pop_front();
                  check("handoff_pc4", PC_4_out, e.pc4);
                  check("handoff_instr", instr_out, e.instr);
                  n_deliv++;
               end
            end
            pend      = bus.imem_req && !bus.imem_ack;
            pend_addr = bus.imem_addr;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] h;
      int          since;
      n_tests        = 0;
      n_fail         = 0;
      n_deliv        = 0;
      seed           = $urandom;
      rst            = 1'b1;
      stall_in       = 1'b0;
      redirect_in    = 1'b0;
      redirect_pc_in = '0;
      ack_mode       = 1;
      restart_stream(TbResetPc);
      repeat (3) step();
      @(negedge clk);
      check("rst_valid", {31'b0, instr_valid_out}, 32'd0);
      check("rst_pc4", PC_4_out, 32'd0);
      check("rst_instr", instr_out, 32'd0);
      check("rst_req", {31'b0, bus.imem_req}, 32'd0);

      // Back-to-back fetch with ack tied high.
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("seq_addr", bus.imem_addr, 32'(4 * k));
         if (k > 0) begin
            check("seq_valid", {31'b0, instr_valid_out}, 32'd1);
            check("seq_pc4", PC_4_out, 32'(4 * k));
         end
         step();
      end

      // Stall fills the buffer, then fetch stops.
      stall_in = 1'b1;
      @(negedge clk);
      h = PC_4_out;
      repeat (5) step();
      @(negedge clk);
      check("full_req", {31'b0, bus.imem_req}, 32'd0);
      check("full_head", PC_4_out, h);
      check("full_valid", {31'b0, instr_valid_out}, 32'd1);
      step();
      stall_in = 1'b0;
      @(negedge clk);
      check("release_req", {31'b0, bus.imem_req}, 32'd0);
      step();
      @(negedge clk);
      check("refetch_req", {31'b0, bus.imem_req}, 32'd1);
      check("refetch_addr", bus.imem_addr, h + 32'd4);

      // Redirect during an outstanding slow request.
      step();
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h10;
      restart_stream(32'h10);
      step();
      ack_mode       = 0;
      redirect_pc_in = 32'h200;
      restart_stream(32'h200);
      @(negedge clk);
      check("drop_addr0", bus.imem_addr, 32'h10);
      step();
      redirect_in = 1'b0;
      @(negedge clk);
      check("drop_req1", {31'b0, bus.imem_req}, 32'd1);
      check("drop_addr1", bus.imem_addr, 32'h10);
      step();
      @(negedge clk);
      check("drop_addr2", bus.imem_addr, 32'h10);
      step();
      ack_mode = 1;
      @(negedge clk);
      check("drop_addr3", bus.imem_addr, 32'h10);
      step();
      @(negedge clk);
      check("new_addr", bus.imem_addr, 32'h200);
      step();
      @(negedge clk);
      check("new_valid", {31'b0, instr_valid_out}, 32'd1);
      check("new_pc4", PC_4_out, 32'h204);

      // Redirect to an unaligned target coincident with ack.
      step();
      redirect_in    = 1'b1;
      redirect_pc_in = 32'h203;
      restart_stream(32'h203);
      step();
      redirect_in = 1'b0;
      @(negedge clk);
      check("coinc_addr", bus.imem_addr, 32'h200);
      check("coinc_valid", {31'b0, instr_valid_out}, 32'd0);

      // Address wrap.
      step();
      redirect_in    = 1'b1;
      redirect_pc_in = 32'hFFFF_FFFC;
      restart_stream(32'hFFFF_FFFC);
      step();
      redirect_in = 1'b0;
      @(negedge clk);
      check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
      step();
      @(negedge clk);
      check("wrap_addr1", bus.imem_addr, 32'h0);
      check("wrap_pc4_0", PC_4_out, 32'h0);
      step();
      @(negedge clk);
      check("wrap_pc4_1", PC_4_out, 32'h4);

      // Reset while waiting with one instruction buffered.
      step();
      stall_in = 1'b1;
      ack_mode = 0;
      step();
      step();
      @(negedge clk);
      check("mid_valid", {31'b0, instr_valid_out}, 32'd1);
      step();
      rst = 1'b1;
      restart_stream(TbResetPc);
      step();
      @(negedge clk);
      check("mid_rst_valid", {31'b0, instr_valid_out}, 32'd0);
      check("mid_rst_pc4", PC_4_out, 32'd0);
      check("mid_rst_instr", instr_out, 32'd0);
      step();
      rst      = 1'b0;
      stall_in = 1'b0;
      ack_mode = 2;
      @(negedge clk);
      check("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
      check("post_rst_addr", bus.imem_addr, TbResetPc);

      // Random traffic.
      since = 0;
      for (int i = 0; i < 1500; i++) begin
         step();
         since++;
         stall_in    = ($urandom_range(0, 3) == 0);
         redirect_in = 1'b0;
         if (since >= 100 || $urandom_range(0, 29) == 0) begin
            redirect_in    = 1'b1;
            redirect_pc_in = $urandom;
            restart_stream(redirect_pc_in);
            since = 0;
         end
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            restart_stream(TbResetPc);
            since = 0;
         end
      end
      step();
      rst         = 1'b0;
      stall_in    = 1'b0;
      redirect_in = 1'b0;
      ack_mode    = 1;
      repeat (10) step();
      check("deliv_enough", {31'b0, (n_deliv >= 200)}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
